// File: rtl/fir_out_fifo.sv
// Output buffer for FIR samples: circular FIFO with a sign-extended, registered read port,
// plus level/full/empty status and sticky overflow/underflow flags.
module fir_out_fifo #(
  parameter int OUT_SIZE = 21,
  parameter int DWIDTH   = 32,
  parameter int DEPTH    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic [OUT_SIZE-1:0]        in_data,
  input  logic                       rd_en,
  output logic [DWIDTH-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [OUT_SIZE-1:0] mem [DEPTH];

  logic [AW-1:0]     wp_reg, wp_next, rp_reg, rp_next;
  logic [LW-1:0]     level_reg, level_next;
  logic              empty_reg, empty_next, full_reg, full_next;
  logic              overflow_reg, overflow_next, underflow_reg, underflow_next;
  logic              rd_valid_reg, rd_valid_next;
  logic [DWIDTH-1:0] rd_data_reg, rd_data_next;

  logic              wr_acc, rd_acc;
  logic [OUT_SIZE-1:0] rd_word;
  logic [DWIDTH-1:0] rd_ext;

  assign rd_word = mem[rp_reg];

  generate
    if (DWIDTH > OUT_SIZE) begin : g_sext
      assign rd_ext = {{(DWIDTH-OUT_SIZE){rd_word[OUT_SIZE-1]}}, rd_word};
    end else begin : g_nosext
      assign rd_ext = rd_word;
    end
  endgenerate

  // A read frees a slot in the same cycle, so a full FIFO can still accept a write.
  always_comb begin
    rd_acc         = 1'b0;
    wr_acc         = 1'b0;
    wp_next        = wp_reg;
    rp_next        = rp_reg;
    level_next     = level_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    rd_valid_next  = 1'b0;
    rd_data_next   = rd_data_reg;

    if (clear) begin
      wp_next        = '0;
      rp_next        = '0;
      level_next     = '0;
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end else begin
      rd_acc = rd_en && !empty_reg;
      wr_acc = in_valid && (!full_reg || rd_acc);

      if (in_valid && !wr_acc) overflow_next = 1'b1;
      if (rd_en && empty_reg)  underflow_next = 1'b1;

      if (wr_acc) wp_next = wp_reg + AW'(1);
      if (rd_acc) begin
        rp_next       = rp_reg + AW'(1);
        rd_valid_next = 1'b1;
        rd_data_next  = rd_ext;
      end

      case ({wr_acc, rd_acc})
        2'b10:   level_next = level_reg + LW'(1);
        2'b01:   level_next = level_reg - LW'(1);
        default: level_next = level_reg;
      endcase
    end

    empty_next = (level_next == '0);
    full_next  = (level_next == LW'(DEPTH));
  end

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wp_reg] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_reg        <= '0;
      rp_reg        <= '0;
      level_reg     <= '0;
      empty_reg     <= 1'b1;
      full_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      rd_valid_reg  <= 1'b0;
      rd_data_reg   <= '0;
    end else begin
      wp_reg        <= wp_next;
      rp_reg        <= rp_next;
      level_reg     <= level_next;
      empty_reg     <= empty_next;
      full_reg      <= full_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
      rd_valid_reg  <= rd_valid_next;
      rd_data_reg   <= rd_data_next;
    end
  end

  assign rd_data   = rd_data_reg;
  assign rd_valid  = rd_valid_reg;
  assign empty     = empty_reg;
  assign full      = full_reg;
  assign level     = level_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule

// File: doc/fir_out_fifo.md
# fir_out_fifo

Output buffer stage directly downstream of the FIR core. It captures each filtered sample (OUT_SIZE bits, two's complement) on the FIR's output valid strobe and stores it in a circular FIFO. It sign-extends samples to the DWIDTH bus width and presents them to the AHB slave read path through a registered read port. It also reports level, full/empty status and sticky overflow/underflow errors.

## Interface
- OUT_SIZE, 21: FIR output sample width (2*BIT_PREC + $clog2(TAPS-1)); signed.
- DWIDTH, 32: read data bus width; must be >= OUT_SIZE.
- DEPTH, 16: FIFO entries; power of two, >= 2.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush of FIFO contents and error flags.
- in_valid  in  1  FIR output sample strobe.
- in_data  in  OUT_SIZE  FIR output sample, two's complement.
- rd_en  in  1  read request from bus side.
- rd_data  out  DWIDTH  sign-extended sample, registered.
- rd_valid  out  1  one-cycle pulse: rd_data updated this cycle.
- empty  out  1  level == 0.
- full  out  1  level == DEPTH.
- level  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; a sample was dropped while full.
- underflow  out  1  sticky; rd_en was asserted while empty.

## Operation
- Storage: DEPTH x OUT_SIZE array; write pointer wp, read pointer rp, each $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0; separate level counter.
- Write accepted when in_valid && !full: mem[wp] <= in_data, wp++.
- Write while full: sample discarded, pointers unchanged, overflow <= 1.
- Read accepted when rd_en && !empty: rd_data <= sign_extend(mem[rp]), rp++, rd_valid <= 1.
- Read while empty: rd_data holds, rd_valid <= 0, underflow <= 1.
- Sign extension: rd_data = {(DWIDTH-OUT_SIZE) copies of bit OUT_SIZE-1, sample}.
- level: +1 on accepted write only, -1 on accepted read only, unchanged when both or neither occur.
- Simultaneous events:
  - Full, with in_valid && rd_en: the read is accepted. The write is also accepted into the freed slot, with no overflow. Level stays DEPTH.
  - Empty, with in_valid && rd_en: the write is accepted. The read is rejected with underflow set; there is no bypass. Level becomes 1.
- clear: highest priority. wp, rp and level go to 0; overflow, underflow and rd_valid go to 0. rd_data holds its value. in_valid and rd_en in the same cycle are ignored, and no flags are set.
- rd_data holds its last value whenever no read is accepted.

## Timing
- Reset values: rd_data 0, rd_valid 0, empty 1, full 0, level 0, overflow 0, underflow 0; wp = rp = 0. Memory contents are don't-care.
- rst is asynchronous on assertion and takes effect mid-operation immediately. All in-flight data is lost.
- Write-to-readable latency: 1 cycle. A sample written at edge N gives empty=0 after edge N, so rd_en is usable at edge N+1.
- Read latency: 1 cycle. rd_en sampled at edge N gives rd_data and rd_valid valid after edge N. rd_valid is high for exactly one cycle per accepted read.
- Back-to-back: one write and one read per cycle are sustained indefinitely.
- empty, full and level are registered and consistent with each other in every cycle.

## Test plan
- Reset, then write 21'h000005, 21'h1FFFFF, 21'h100000 on consecutive cycles, then read 3 times. Required: rd_data = 32'h00000005, 32'hFFFFFFFF, 32'hFFF00000 in order; rd_valid pulses ×3; level goes 3 -> 0; empty=1 at end.
- Write 16 samples 0..15 (full=1, level=16), then write 21'h0000AA. Required: overflow=1, and reading 16 times returns 0..15 with 0xAA absent.
- Read while empty. Required: underflow=1, rd_valid=0, rd_data unchanged. Then assert clear. Required: underflow=0, overflow=0, level=0.
- Fill to 16, then hold in_valid and rd_en for 40 cycles with an incrementing input. Required: level stays 16, no overflow, and output order is strictly sequential across pointer wrap.
- From empty, assert in_valid and rd_en in the same cycle with 21'h000007. Required: underflow=1, level=1; the next read returns 32'h00000007.
- Fill 5 entries, then assert rst asynchronously between clock edges. Required: all outputs return to reset values immediately, and a subsequent read sets underflow.
